// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time
// over req/ack and buffers returned words with their PCs in a prefetch FIFO.
module inst_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   output logic                     o_mem_req,
   output logic [63:0]              o_mem_addr,
   input  logic                     i_mem_ack,
   input  logic [31:0]              i_mem_rdata,
   input  logic                     i_redirect,
   input  logic [63:0]              i_redirect_pc,
   output logic                     o_inst_valid,
   output logic [31:0]              o_inst,
   output logic [63:0]              o_inst_pc,
   input  logic                     i_inst_ready,
   output logic [$clog2(DEPTH):0]   o_fifo_level
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP
   } state_t;

   state_t      r_state, w_state_next;
   logic [63:0] r_fetch_pc;
   logic [63:0] r_drop_addr;
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic [63:0] r_pc_mem   [DEPTH];
   logic [31:0] r_word_mem [DEPTH];

   logic [AW:0] w_level;
   logic [AW:0] w_level_next;
   logic        w_push;
   logic        w_pop;
   logic        w_space;
   logic [AW-1:0] w_rd_idx;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_level      = r_wr_ptr - r_rd_ptr;
      w_pop        = (w_level != '0) && i_inst_ready;
      w_push       = (r_state == S_WAIT) && i_mem_ack && !i_redirect;
      w_level_next = w_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      w_space      = (w_level_next != DEPTH_L);
      w_rd_idx     = r_rd_ptr[AW-1:0];

      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (!i_redirect && w_space) w_state_next = S_WAIT;
         S_WAIT: begin
            if (i_redirect)     w_state_next = i_mem_ack ? S_IDLE : S_DROP;
            else if (i_mem_ack) w_state_next = w_space ? S_WAIT : S_IDLE;
         end
         // Requests are never withdrawn: the stale one must complete first.
         S_DROP: if (i_mem_ack) w_state_next = i_redirect ? S_IDLE : S_WAIT;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_drop_addr <= RESET_PC;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
      end else begin
         r_state <= w_state_next;
         if (i_redirect) begin
            // Redirect wins over push and pop; the popped head is lost too.
            r_fetch_pc <= {i_redirect_pc[63:2], 2'b00};
            r_rd_ptr   <= r_wr_ptr;
            if (r_state == S_WAIT) r_drop_addr <= r_fetch_pc;
         end else begin
            if (w_push) begin
               r_wr_ptr   <= r_wr_ptr + 1'b1;
               r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr[AW-1:0]]   <= r_fetch_pc;
         r_word_mem[r_wr_ptr[AW-1:0]] <= i_mem_rdata;
      end
   end

   assign o_mem_req    = (r_state != S_IDLE);
   assign o_mem_addr   = (r_state == S_DROP) ? r_drop_addr : r_fetch_pc;
   assign o_inst_valid = (w_level != '0);
   assign o_inst       = o_inst_valid ? r_word_mem[w_rd_idx] : NOP;
   assign o_inst_pc    = o_inst_valid ? r_pc_mem[w_rd_idx] : 64'h0;
   assign o_fifo_level = w_level;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fill, streaming, variable latency,
// redirects and asynchronous reset during a dropped request.
module tb_inst_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   // Memory model: acks a request after mdl_lat idle cycles; or manual control.
   logic        mdl_en = 1'b0;
   int          mdl_lat = 0;
   int          mdl_cnt = 0;
   logic        mdl_ack = 1'b0;
   logic [31:0] mdl_rdata = 32'h0;
   logic        man_ack = 1'b0;
   logic [31:0] man_rdata = 32'h0;

   assign mem_ack   = mdl_en ? mdl_ack : man_ack;
   assign mem_rdata = mdl_en ? mdl_rdata : man_rdata;

   inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .i_mem_ack     (mem_ack),
      .i_mem_rdata   (mem_rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst_valid  (inst_valid),
      .o_inst        (inst),
      .o_inst_pc     (inst_pc),
      .i_inst_ready  (inst_ready),
      .o_fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) begin
      #1;
      if (!rst_n || !mdl_en || !mem_req) begin
         mdl_ack = 1'b0;
         mdl_cnt = 0;
      end else if (mdl_cnt >= mdl_lat) begin
         mdl_ack   = 1'b1;
         mdl_rdata = exp_word(mem_addr);
         mdl_cnt   = 0;
      end else begin
         mdl_ack = 1'b0;
         mdl_cnt++;
      end
   end

   // A push can only land when the FIFO has room.
   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ack && !redirect) begin
         checks++;
         if (fifo_level == 3'd4) begin
            $display("FAIL push_into_full: level %0d at push", fifo_level);
            errors++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en, input int lat);
      rst_n       = 1'b0;
      redirect    = 1'b0;
      inst_ready  = 1'b0;
      man_ack     = 1'b0;
      mdl_en      = en;
      mdl_lat     = lat;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin $display("FAIL rst_req: got %0b want 0", mem_req); errors++; end
      checks++; if (mem_addr !== RESET_PC) begin $display("FAIL rst_addr: got %h want %h", mem_addr, RESET_PC); errors++; end
      checks++; if (inst_valid !== 1'b0) begin $display("FAIL rst_valid: got %0b want 0", inst_valid); errors++; end
      checks++; if (inst !== NOP) begin $display("FAIL rst_inst: got %h want %h", inst, NOP); errors++; end
      checks++; if (inst_pc !== 64'h0) begin $display("FAIL rst_pc: got %h want 0", inst_pc); errors++; end
      checks++; if (fifo_level !== 3'd0) begin $display("FAIL rst_level: got %0d want 0", fifo_level); errors++; end
   endtask

   task automatic test_fill();
      do_reset(1'b1, 0);
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin $display("FAIL fill_first_req: got req=%0b addr=%h want 1/1000", mem_req, mem_addr); errors++; end
      checks++; if (inst_valid !== 1'b0) begin $display("FAIL fill_first_valid: got %0b want 0", inst_valid); errors++; end
      repeat (7) tick();
      checks++; if (fifo_level !== 3'd4) begin $display("FAIL fill_level: got %0d want 4", fifo_level); errors++; end
      checks++; if (mem_req !== 1'b0) begin $display("FAIL fill_req_stop: got %0b want 0", mem_req); errors++; end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h1000 || inst !== exp_word(64'h1000)) begin
         $display("FAIL fill_head: got v=%0b pc=%h w=%h want 1/1000/%h", inst_valid, inst_pc, inst, exp_word(64'h1000)); errors++; end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++; if (inst_pc !== 64'h1004 || fifo_level !== 3'd3) begin $display("FAIL fill_pop: got pc=%h lvl=%0d want 1004/3", inst_pc, fifo_level); errors++; end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1010) begin $display("FAIL fill_refetch: got req=%0b addr=%h want 1/1010", mem_req, mem_addr); errors++; end
   endtask

   task automatic test_stream();
      logic [63:0] exp_pc;
      do_reset(1'b1, 0);
      inst_ready = 1'b1;
      tick();
      checks++; if (inst_valid !== 1'b0) begin $display("FAIL stream_valid0: got %0b want 0", inst_valid); errors++; end
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_pc = 64'h1000 + 64'(4 * i);
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_word(exp_pc) || fifo_level !== 3'd1) begin
            $display("FAIL stream_%0d: got v=%0b pc=%h w=%h lvl=%0d want 1/%h/%h/1", i, inst_valid, inst_pc, inst, fifo_level, exp_pc, exp_word(exp_pc));
            errors++;
         end
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_var_latency();
      do_reset(1'b1, 3);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || inst_valid !== 1'b0) begin
            $display("FAIL lat_hold_%0d: got req=%0b addr=%h v=%0b want 1/1000/0", i, mem_req, mem_addr, inst_valid); errors++;
         end
      end
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h1000 || mem_addr !== 64'h1004 || fifo_level !== 3'd1) begin
         $display("FAIL lat_first: got v=%0b pc=%h addr=%h lvl=%0d want 1/1000/1004/1", inst_valid, inst_pc, mem_addr, fifo_level); errors++; end
      repeat (8) tick();
      checks++; if (fifo_level !== 3'd3 || mem_addr !== 64'h100C || inst_pc !== 64'h1000) begin
         $display("FAIL lat_three: got lvl=%0d addr=%h pc=%h want 3/100c/1000", fifo_level, mem_addr, inst_pc); errors++; end
      inst_ready = 1'b1;
      tick();
      checks++; if (inst_pc !== 64'h1004 || inst !== exp_word(64'h1004)) begin $display("FAIL lat_order1: got pc=%h w=%h want 1004", inst_pc, inst); errors++; end
      tick();
      checks++; if (inst_pc !== 64'h1008 || inst !== exp_word(64'h1008)) begin $display("FAIL lat_order2: got pc=%h w=%h want 1008", inst_pc, inst); errors++; end
      tick();
      checks++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 64'h0) begin
         $display("FAIL lat_empty: got v=%0b w=%h pc=%h want 0/%h/0", inst_valid, inst, inst_pc, NOP); errors++; end
      inst_ready = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset(1'b0, 0);
      tick();
      man_ack = 1'b1; man_rdata = exp_word(64'h1000);
      tick();
      man_rdata = exp_word(64'h1004);
      tick();
      man_ack = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1008 || fifo_level !== 3'd2) begin
         $display("FAIL rdw_pre: got req=%0b addr=%h lvl=%0d want 1/1008/2", mem_req, mem_addr, fifo_level); errors++; end
      redirect = 1'b1; redirect_pc = 64'h2002;
      tick();
      redirect = 1'b0;
      checks++; if (fifo_level !== 3'd0 || inst_valid !== 1'b0) begin $display("FAIL rdw_flush: got lvl=%0d v=%0b want 0/0", fifo_level, inst_valid); errors++; end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1008) begin $display("FAIL rdw_drop_hold: got req=%0b addr=%h want 1/1008", mem_req, mem_addr); errors++; end
      man_ack = 1'b1; man_rdata = exp_word(64'h1008);
      tick();
      man_ack = 1'b0;
      checks++; if (fifo_level !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 64'h2000) begin
         $display("FAIL rdw_newreq: got lvl=%0d req=%0b addr=%h want 0/1/2000", fifo_level, mem_req, mem_addr); errors++; end
      man_ack = 1'b1; man_rdata = exp_word(64'h2000);
      tick();
      man_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || inst !== exp_word(64'h2000) || fifo_level !== 3'd1) begin
         $display("FAIL rdw_first: got v=%0b pc=%h w=%h lvl=%0d want 1/2000/%h/1", inst_valid, inst_pc, inst, fifo_level, exp_word(64'h2000)); errors++; end
   endtask

   task automatic test_redirect_ack_pop();
      do_reset(1'b0, 0);
      tick();
      man_ack = 1'b1; man_rdata = exp_word(64'h1000);
      tick();
      man_rdata = exp_word(64'h1004);
      tick();
      man_rdata = exp_word(64'h1008);
      inst_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 64'h3000;
      tick();
      man_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
      checks++; if (fifo_level !== 3'd0 || inst_valid !== 1'b0 || inst_pc !== 64'h0) begin
         $display("FAIL rap_flush: got lvl=%0d v=%0b pc=%h want 0/0/0", fifo_level, inst_valid, inst_pc); errors++; end
      checks++; if (mem_req !== 1'b0) begin $display("FAIL rap_idle: got req=%0b want 0", mem_req); errors++; end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h3000) begin $display("FAIL rap_req: got req=%0b addr=%h want 1/3000", mem_req, mem_addr); errors++; end
      man_ack = 1'b1; man_rdata = exp_word(64'h3000);
      tick();
      man_ack = 1'b0;
      checks++; if (inst_pc !== 64'h3000 || fifo_level !== 3'd1) begin $display("FAIL rap_first: got pc=%h lvl=%0d want 3000/1", inst_pc, fifo_level); errors++; end
   endtask

   task automatic test_reset_mid_drop();
      do_reset(1'b0, 0);
      tick();
      man_ack = 1'b1; man_rdata = exp_word(64'h1000);
      tick();
      man_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 64'h4000;
      tick();
      redirect = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1004 || fifo_level !== 3'd0) begin
         $display("FAIL rmd_drop: got req=%0b addr=%h lvl=%0d want 1/1004/0", mem_req, mem_addr, fifo_level); errors++; end
      redirect = 1'b1; redirect_pc = 64'h5004;
      tick();
      redirect = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1004) begin $display("FAIL rmd_drop2: got req=%0b addr=%h want 1/1004", mem_req, mem_addr); errors++; end
      man_ack = 1'b1; man_rdata = exp_word(64'h1000);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_addr !== RESET_PC) begin $display("FAIL rmd_async: got req=%0b addr=%h want 0/%h", mem_req, mem_addr, RESET_PC); errors++; end
      checks++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 64'h0 || fifo_level !== 3'd0) begin
         $display("FAIL rmd_async_out: got v=%0b w=%h pc=%h lvl=%0d want 0/%h/0/0", inst_valid, inst, inst_pc, fifo_level, NOP); errors++; end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC || fifo_level !== 3'd0) begin
         $display("FAIL rmd_restart: got req=%0b addr=%h lvl=%0d want 1/%h/0", mem_req, mem_addr, fifo_level, RESET_PC); errors++; end
      tick();
      man_ack = 1'b0;
      checks++; if (inst_pc !== RESET_PC || inst !== exp_word(RESET_PC) || fifo_level !== 3'd1) begin
         $display("FAIL rmd_first: got pc=%h w=%h lvl=%0d want %h/1", inst_pc, inst, fifo_level, RESET_PC); errors++; end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_var_latency();
      test_redirect_wait();
      test_redirect_ack_pop();
      test_reset_mid_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage directly upstream of the single-cycle CPU core. It owns the fetch PC, issues one-at-a-time word reads to an instruction memory with variable latency over a req/ack handshake, and buffers returned words with their PCs in a small prefetch FIFO. The core consumes instructions over a valid/ready handshake and redirects fetch on a taken branch. A redirect flushes the buffer and discards any in-flight word.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 64'h0: first fetch address after reset.
- NOP, 32'h00000013: value driven on inst when inst_valid=0.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  fetch request; held until mem_ack.
- mem_addr  output  64  word address of the request; stable while mem_req=1; bits [1:0] always 0.
- mem_ack  input  1  one-cycle pulse completing the current request; ignored when mem_req=0.
- mem_rdata  input  32  instruction word; valid in the mem_ack cycle.
- redirect  input  1  one-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  input  64  new fetch address; bits [1:0] ignored (forced 0).
- inst_valid  output  1  FIFO head valid.
- inst  output  32  FIFO head word; NOP when empty.
- inst_pc  output  64  PC of FIFO head; 0 when empty.
- inst_ready  input  1  core accepts head; pop when inst_valid & inst_ready.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Registers: fetch_pc, FIFO (DEPTH x {pc, word}), rd/wr pointers with wrap bit, state.
- States: IDLE (no request), WAIT (request outstanding, data to be kept), DROP (request outstanding, data to be discarded).
- IDLE -> WAIT when space = DEPTH - level_next > 0 and no redirect this cycle; mem_req=1, mem_addr=fetch_pc.
- WAIT, mem_ack, no redirect: push {fetch_pc, mem_rdata}; fetch_pc += 4 (64-bit wrap to 0); stay in WAIT with new address if space remains after push and same-cycle pop, else IDLE.
- WAIT, redirect (with or without mem_ack): flush FIFO; fetch_pc = redirect_pc & ~3; ack data discarded. If mem_ack same cycle -> IDLE-issue (WAIT at redirect_pc next cycle). Else -> DROP.
- DROP: mem_req held at old address (requests are never withdrawn); on mem_ack discard data and go to WAIT at fetch_pc. Further redirect in DROP only updates fetch_pc and flushes.
- IDLE, redirect: flush, load fetch_pc, request next cycle.
- Redirect has priority over pop and push in the same cycle; popped head is lost.
- Push into full FIFO cannot occur (request gated by space); bench asserts it.
- Pop on empty has no effect.

## Timing
- Reset (reset=0, asynchronous): mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0, fifo_level=0, state IDLE, fetch_pc=RESET_PC.
- First rising edge after reset release: mem_req=1, mem_addr=RESET_PC.
- mem_ack at edge N pushes; inst_valid=1 from cycle after N (one-cycle push-to-output latency).
- Back-to-back: with space, next request presented the cycle after mem_ack (mem_req stays 1, address advances by 4); sustained throughput one word per cycle with zero-wait memory.
- Pop visible next cycle: head advances, fifo_level decrements; push and pop in same cycle keep level.
- Redirect at edge R: inst_valid=0 and fifo_level=0 from cycle after R; first redirected word earliest at R+2 with zero-latency ack.
- Reset asserted mid-request: all state cleared immediately; pending ack after reset release while mem_req=0 is ignored.

## Test plan
- Reset/fill: RESET_PC=0x1000, ack every cycle, inst_ready=0 -> words at 0x1000..0x100C buffered, fifo_level=4, mem_req=0 thereafter.
- Stream: ack every cycle, inst_ready=1 -> inst_pc sequence 0x1000,0x1004,0x1008,... one per cycle, fifo_level constant, no gaps after first word.
- Variable latency: ack 3 cycles after each request -> mem_addr stable across wait cycles, FIFO order preserved.
- Redirect in WAIT: request at 0x1008 outstanding, redirect to 0x2002 -> FIFO flushed, 0x1008 data discarded on ack, next request mem_addr=0x2000, first inst_pc=0x2000.
- Redirect with simultaneous ack and pop -> neither pushed nor popped word survives, fifo_level=0, next request at redirect_pc.
- Async reset mid-DROP -> outputs at reset values immediately, first fetch at RESET_PC after release.
